// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity frame checker.
package parity_pkg;

  // Controller states: collecting frame words, or presenting a held result.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Widest error counter supported; the saturation value is sliced from this.
  localparam int SAT_MAX_W = 64;
  localparam logic [SAT_MAX_W-1:0] SAT_ALL_ONES = '1;

  // Counter width for a 0..n-1 count, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/parity_led_heartbeat.sv
// Heartbeat LED: blinks with a period of 2*LED_DIV clocks while the link is
// clean, is forced on after an error and restarts dark when errors are cleared.
module parity_led_heartbeat
  import parity_pkg::*;
#(
  parameter int LED_DIV = 5
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic force_on,
  input  logic restart,
  output logic led
);

  localparam int DIV_W = clog2_min1(LED_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(LED_DIV - 1);

  logic [DIV_W-1:0] div_q;

  // Divider and LED; forcing wins over restart so a same-cycle error stays visible.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_q <= '0;
      led   <= 1'b0;
    end else if (force_on) begin
      div_q <= '0;
      led   <= 1'b1;
    end else if (restart) begin
      div_q <= '0;
      led   <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
      led   <= ~led;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/parity_frame_checker.sv
// Frame parity generator/checker: folds the parity of FRAME_LEN words taken on
// a valid/ready stream, holds the result on an output handshake and keeps a
// saturating count plus sticky flag of frames whose parity disagreed with in_par.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4,
  parameter int ODD       = 0,
  parameter int ERR_CNT_W = 8,
  parameter int LED_DIV   = 5
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_par,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_parity,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 err_sticky,
  input  logic                 clr,
  output logic                 led
);

  localparam int IDX_W = clog2_min1(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = SAT_ALL_ONES[ERR_CNT_W-1:0];
  localparam logic ODD_B = (ODD != 0);

  state_t state_q;
  state_t state_d;

  logic [IDX_W-1:0]     idx_p0;
  logic                 acc_p0;
  logic                 acc_next;
  logic                 accept;
  logic                 frame_done;
  logic                 frame_par;
  logic                 frame_err;
  logic                 par_p1;
  logic                 err_p1;
  logic [ERR_CNT_W-1:0] cnt_d;
  logic                 sticky_d;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_MAX) ? v : v + ERR_CNT_W'(1);
  endfunction

  assign accept     = in_valid && in_ready;
  assign frame_done = accept && (idx_p0 == LAST_IDX);
  assign acc_next   = acc_p0 ^ (^in_data);
  assign frame_par  = acc_next ^ ODD_B;
  assign frame_err  = frame_par != in_par;

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ACCUM;
    else            state_q <= state_d;
  end

  // Next state: enter HOLD on the final word, leave once the result is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (frame_done) state_d = HOLD;
      HOLD:    if (out_ready)  state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Handshake outputs decoded from state; HOLD blocks input, costing one bubble.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM:   in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // ---- stage p0: word index and running parity; p1: frame result ----
  // Fold each accepted word; the final word launches the result and rearms p0.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx_p0 <= '0;
      acc_p0 <= 1'b0;
      par_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else if (accept) begin
      if (frame_done) begin
        idx_p0 <= '0;
        acc_p0 <= 1'b0;
        par_p1 <= frame_par;
        err_p1 <= frame_err;
      end else begin
        idx_p0 <= idx_p0 + IDX_W'(1);
        acc_p0 <= acc_next;
      end
    end
  end

  assign out_parity = par_p1;
  assign out_err    = err_p1;

  // Error bookkeeping: clear first, then count an erroring frame once as it enters HOLD.
  always_comb begin
    cnt_d    = err_count;
    sticky_d = err_sticky;
    if (clr) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end
    if (frame_done && frame_err) begin
      cnt_d    = sat_inc(cnt_d);
      sticky_d = 1'b1;
    end
  end

  // Error counter and sticky flag registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else begin
      err_count  <= cnt_d;
      err_sticky <= sticky_d;
    end
  end

  // The LED follows the next sticky value so it lights in the same edge as the flag.
  parity_led_heartbeat #(
    .LED_DIV (LED_DIV)
  ) u_led (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .force_on  (sticky_d),
    .restart   (clr),
    .led       (led)
  );

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: three instances (even, odd, 2-bit counter)
// share one stimulus stream and are compared against a frame-level model.
module tb_parity_frame_checker;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_par;
  logic       out_ready;
  logic       clr;

  logic [2:0] in_ready_v, out_valid_v, out_parity_v, out_err_v, err_sticky_v, led_v;
  logic [7:0] cnt_even, cnt_odd;
  logic [1:0] cnt_sat;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] ODD_OF = 3'b010;
  int         cnt_max [3] = '{255, 255, 3};
  int         exp_cnt [3];
  logic [2:0] exp_sticky_v;
  logic [2:0] exp_par_v;
  logic [2:0] exp_err_v;

  always #5 sys_clk = ~sys_clk;

  parity_frame_checker #(.DATA_W(8), .FRAME_LEN(4), .ODD(0), .ERR_CNT_W(8), .LED_DIV(5)) dut_even (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .in_data(in_data), .in_par(in_par), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .out_parity(out_parity_v[0]), .out_err(out_err_v[0]), .err_count(cnt_even),
    .err_sticky(err_sticky_v[0]), .clr(clr), .led(led_v[0]));

  parity_frame_checker #(.DATA_W(8), .FRAME_LEN(4), .ODD(1), .ERR_CNT_W(8), .LED_DIV(5)) dut_odd (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .in_data(in_data), .in_par(in_par), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .out_parity(out_parity_v[1]), .out_err(out_err_v[1]), .err_count(cnt_odd),
    .err_sticky(err_sticky_v[1]), .clr(clr), .led(led_v[1]));

  parity_frame_checker #(.DATA_W(8), .FRAME_LEN(4), .ODD(0), .ERR_CNT_W(2), .LED_DIV(5)) dut_sat (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .in_data(in_data), .in_par(in_par), .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .out_parity(out_parity_v[2]), .out_err(out_err_v[2]), .err_count(cnt_sat),
    .err_sticky(err_sticky_v[2]), .clr(clr), .led(led_v[2]));

  function automatic int get_cnt(input int i);
    case (i)
      0:       return int'(cnt_even);
      1:       return int'(cnt_odd);
      default: return int'(cnt_sat);
    endcase
  endfunction

  // Frame-level reference: parity of all 32 bits, then the error rules.
  function automatic void model_frame(input logic [31:0] frame, input logic par, input bit do_clr);
    logic p;
    p = ^frame;
    for (int i = 0; i < 3; i++) begin
      exp_par_v[i] = p ^ ODD_OF[i];
      exp_err_v[i] = (exp_par_v[i] != par);
      if (do_clr) begin
        exp_cnt[i]      = 0;
        exp_sticky_v[i] = 1'b0;
      end
      if (exp_err_v[i]) begin
        exp_cnt[i]      = (exp_cnt[i] < cnt_max[i]) ? exp_cnt[i] + 1 : cnt_max[i];
        exp_sticky_v[i] = 1'b1;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    exp_sticky_v = 3'b000;
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Drives one frame (optional idle gaps), holds the result `hold` extra cycles,
  // then completes the handshake. Reports observations and a protocol-anomaly count.
  task automatic run_frame(input logic [31:0] frame, input logic par, input int hold,
                           input bit do_clr, input bit gaps,
                           output logic [2:0] par_o, output logic [2:0] err_o,
                           output logic [2:0] led_and, output int hold_cycles, output int bad);
    bad = 0;
    hold_cycles = 0;
    led_and = 3'b111;
    out_ready = 1'b0;
    if (in_ready_v !== 3'b111) bad++;
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          in_valid = 1'b0; in_data = 8'($urandom); in_par = 1'($urandom);
          step();
          if (out_valid_v !== 3'b000 || in_ready_v !== 3'b111) bad++;
        end
      end
      in_valid = 1'b1;
      in_data  = frame[8*i +: 8];
      in_par   = (i == 3) ? par : 1'($urandom);
      clr      = (i == 3) ? do_clr : 1'b0;
      step();
      if (i < 3 && (out_valid_v !== 3'b000 || in_ready_v !== 3'b111)) bad++;
    end
    in_valid = 1'b0;
    clr = 1'b0;
    if (out_valid_v !== 3'b111 || in_ready_v !== 3'b000) bad++;
    par_o = out_parity_v;
    err_o = out_err_v;
    led_and &= led_v;
    hold_cycles = 1;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom); in_data = 8'($urandom); in_par = 1'($urandom);
      step();
      if (out_valid_v === 3'b111) hold_cycles++;
      if (out_valid_v !== 3'b111 || in_ready_v !== 3'b000 ||
          out_parity_v !== par_o || out_err_v !== err_o) bad++;
      led_and &= led_v;
    end
    // Handshake cycle: the offered word must be ignored.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'($urandom);
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    if (out_valid_v !== 3'b000 || in_ready_v !== 3'b111) bad++;
  endtask

  task automatic test_reset();
    int toggles;
    logic prev;
    sys_rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_par = 1'b0; out_ready = 1'b0; clr = 1'b0;
    step(); step();
    sys_rst_n = 1'b1;
    model_reset();
    checks++;
    if (out_valid_v !== 3'b000 || in_ready_v !== 3'b111 || out_parity_v !== 3'b000 ||
        out_err_v !== 3'b000 || err_sticky_v !== 3'b000 || led_v !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got valid=%b ready=%b par=%b err=%b sticky=%b led=%b exp 000 111 000 000 000 000",
               out_valid_v, in_ready_v, out_parity_v, out_err_v, err_sticky_v, led_v);
    end
    checks++;
    if (cnt_even !== 8'd0 || cnt_odd !== 8'd0 || cnt_sat !== 2'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d/%0d/%0d exp=0/0/0", cnt_even, cnt_odd, cnt_sat);
    end
    toggles = 0;
    prev = led_v[0];
    for (int k = 1; k <= 30; k++) begin
      logic e;
      step();
      e = ((k / 5) % 2) == 1;
      if (led_v[0] !== prev) toggles++;
      prev = led_v[0];
      checks++;
      if (led_v !== {3{e}}) begin
        failures++;
        $display("FAIL idle_led clk=%0d got=%b exp=%b", k, led_v, {3{e}});
      end
    end
    checks++;
    if (toggles != 6) begin
      failures++;
      $display("FAIL idle_toggles got=%0d exp=6", toggles);
    end
    checks++;
    if (out_valid_v !== 3'b000 || cnt_even !== 8'd0) begin
      failures++;
      $display("FAIL idle_quiet got valid=%b cnt=%0d exp valid=000 cnt=0", out_valid_v, cnt_even);
    end
  endtask

  task automatic test_clean_frame();
    logic [2:0] p, e, l;
    int hc, bad;
    run_frame(32'h0000_0201, 1'b0, 0, 1'b0, 1'b0, p, e, l, hc, bad);
    model_frame(32'h0000_0201, 1'b0, 1'b0);
    checks++;
    if (bad !== 0 || hc !== 1) begin
      failures++;
      $display("FAIL clean_protocol got anomalies=%0d hold=%0d exp anomalies=0 hold=1", bad, hc);
    end
    checks++;
    if (p !== exp_par_v || e !== exp_err_v) begin
      failures++;
      $display("FAIL clean_result got par=%b err=%b exp par=%b err=%b", p, e, exp_par_v, exp_err_v);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_cnt(i) !== exp_cnt[i]) begin
        failures++;
        $display("FAIL clean_cnt%0d got=%0d exp=%0d", i, get_cnt(i), exp_cnt[i]);
      end
    end
  endtask

  task automatic test_hold_error();
    logic [2:0] p, e, l;
    int hc, bad;
    run_frame(32'h0000_0007, 1'b0, 5, 1'b0, 1'b0, p, e, l, hc, bad);
    model_frame(32'h0000_0007, 1'b0, 1'b0);
    checks++;
    if (bad !== 0 || hc !== 6) begin
      failures++;
      $display("FAIL hold_protocol got anomalies=%0d hold=%0d exp anomalies=0 hold=6", bad, hc);
    end
    checks++;
    if (p !== exp_par_v || e !== exp_err_v || p[0] !== 1'b1 || e[0] !== 1'b1) begin
      failures++;
      $display("FAIL hold_result got par=%b err=%b exp par=%b err=%b", p, e, exp_par_v, exp_err_v);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_cnt(i) !== exp_cnt[i]) begin
        failures++;
        $display("FAIL hold_cnt%0d got=%0d exp=%0d", i, get_cnt(i), exp_cnt[i]);
      end
    end
    checks++;
    if (err_sticky_v !== exp_sticky_v || (l & exp_sticky_v) !== exp_sticky_v) begin
      failures++;
      $display("FAIL hold_sticky_led got sticky=%b led_held=%b exp sticky=%b", err_sticky_v, l, exp_sticky_v);
    end
  endtask

  task automatic test_odd();
    logic [2:0] p, e, l;
    int hc, bad;
    run_frame(32'hFFFF_FFFF, 1'b1, 1, 1'b0, 1'b1, p, e, l, hc, bad);
    model_frame(32'hFFFF_FFFF, 1'b1, 1'b0);
    checks++;
    if (p[1] !== 1'b1 || e[1] !== 1'b0 || p !== exp_par_v || e !== exp_err_v || bad !== 0) begin
      failures++;
      $display("FAIL odd_result got par=%b err=%b anomalies=%0d exp par=%b err=%b", p, e, bad, exp_par_v, exp_err_v);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_cnt(i) !== exp_cnt[i]) begin
        failures++;
        $display("FAIL odd_cnt%0d got=%0d exp=%0d", i, get_cnt(i), exp_cnt[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [2:0] p, e, l;
    logic [31:0] fr;
    logic par;
    int hc, bad;
    clr = 1'b1;
    step();
    clr = 1'b0;
    model_reset();
    checks++;
    if (cnt_even !== 8'd0 || cnt_odd !== 8'd0 || cnt_sat !== 2'd0 || err_sticky_v !== 3'b000 || led_v !== 3'b000) begin
      failures++;
      $display("FAIL clr_state got cnt=%0d/%0d/%0d sticky=%b led=%b exp 0/0/0 000 000",
               cnt_even, cnt_odd, cnt_sat, err_sticky_v, led_v);
    end
    for (int f = 0; f < 6; f++) begin
      fr  = $urandom;
      par = ~(^fr);
      run_frame(fr, par, $urandom_range(0, 2), (f == 5), 1'b1, p, e, l, hc, bad);
      model_frame(fr, par, (f == 5));
      checks++;
      if (int'(cnt_sat) !== ((f == 5) ? 1 : ((f + 1 < 3) ? f + 1 : 3))) begin
        failures++;
        $display("FAIL sat_seq frame=%0d got=%0d exp=%0d", f, cnt_sat,
                 (f == 5) ? 1 : ((f + 1 < 3) ? f + 1 : 3));
      end
      checks++;
      if (bad !== 0 || e !== exp_err_v || err_sticky_v !== exp_sticky_v) begin
        failures++;
        $display("FAIL sat_frame frame=%0d got anomalies=%0d err=%b sticky=%b exp anomalies=0 err=%b sticky=%b",
                 f, bad, e, err_sticky_v, exp_err_v, exp_sticky_v);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (get_cnt(i) !== exp_cnt[i]) begin
          failures++;
          $display("FAIL sat_cnt%0d frame=%0d got=%0d exp=%0d", i, f, get_cnt(i), exp_cnt[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] p, e, l;
    logic [31:0] fr;
    logic par;
    int hc, bad;
    for (int f = 0; f < 8; f++) begin
      fr  = $urandom;
      par = 1'($urandom);
      run_frame(fr, par, $urandom_range(0, 3), 1'b0, 1'b1, p, e, l, hc, bad);
      model_frame(fr, par, 1'b0);
      checks++;
      if (bad !== 0 || p !== exp_par_v || e !== exp_err_v || err_sticky_v !== exp_sticky_v) begin
        failures++;
        $display("FAIL rand_frame frame=%0d data=%h got anomalies=%0d par=%b err=%b sticky=%b exp 0 par=%b err=%b sticky=%b",
                 f, fr, bad, p, e, err_sticky_v, exp_par_v, exp_err_v, exp_sticky_v);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (get_cnt(i) !== exp_cnt[i]) begin
          failures++;
          $display("FAIL rand_cnt%0d frame=%0d got=%0d exp=%0d", i, f, get_cnt(i), exp_cnt[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [2:0] p, e, l;
    logic [31:0] fr;
    int hc, bad;
    in_valid = 1'b1; in_data = 8'h01; step();
    in_data = 8'h00; step();
    in_valid = 1'b0;
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (cnt_even !== 8'd0 || cnt_sat !== 2'd0 || err_sticky_v !== 3'b000 ||
        in_ready_v !== 3'b111 || out_valid_v !== 3'b000 || led_v !== 3'b000) begin
      failures++;
      $display("FAIL async_reset got cnt=%0d/%0d sticky=%b ready=%b valid=%b led=%b exp 0/0 000 111 000 000",
               cnt_even, cnt_sat, err_sticky_v, in_ready_v, out_valid_v, led_v);
    end
    step();
    sys_rst_n = 1'b1;
    model_reset();
    fr = $urandom;
    run_frame(fr, ^fr, 0, 1'b0, 1'b0, p, e, l, hc, bad);
    model_frame(fr, ^fr, 1'b0);
    checks++;
    if (bad !== 0 || p !== exp_par_v || e !== exp_err_v) begin
      failures++;
      $display("FAIL midframe_result got anomalies=%0d par=%b err=%b exp anomalies=0 par=%b err=%b",
               bad, p, e, exp_par_v, exp_err_v);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_cnt(i) !== exp_cnt[i]) begin
        failures++;
        $display("FAIL midframe_cnt%0d got=%0d exp=%0d", i, get_cnt(i), exp_cnt[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_hold_error();
    test_odd();
    test_saturation();
    test_random();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
